// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous ROM and buffers tagged words for decode.
// Optional IF_PERF_CNT_EN adds the Perf_fetched / Perf_flushes counters.
module fetch_queue_stage #(
    parameter int              XLEN     = 32,
    parameter int              AW       = 10,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Fetch_en,
    input  logic            Redirect,
    input  logic [XLEN-1:0] Redirect_base,
    input  logic [XLEN-1:0] Redirect_immed,
    output logic            Imem_en,
    output logic [AW-1:0]   Imem_addr,
    input  logic [XLEN-1:0] Imem_rdata,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] Instr_PC,
    output logic            Instr_valid,
    input  logic            Instr_ready,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]     Perf_fetched,
    output logic [31:0]     Perf_flushes,
`endif
    output logic [1:0]      Dbg_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_KILL  = 2'd2
    } state_e;

    // Handshake: a head word transfers on a cycle where Instr_valid and Instr_ready
    // are both high at the rising edge; Instr_valid never depends on Instr_ready.

    state_e          state_q;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tag_q;
    logic            inflight_q;
    logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
`ifdef IF_PERF_CNT_EN
    logic [31:0]     fetched_q, flushes_q;
`endif

    logic [CW:0]     used;
    logic            issue_cond;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirect_sum;
    logic [XLEN-1:0] redirect_tgt;

    // In-flight word holds a credit so its push can never overflow the queue.
    assign used         = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign issue_cond   = Fetch_en & (used < DEPTH_W);
    assign Imem_en      = issue_cond & ~Redirect & Reset;
    assign Imem_addr    = pc_q[AW+1:2];

    assign push         = inflight_q & ~Redirect;
    assign Instr_valid  = (count_q != '0) & ~Redirect;
    assign pop          = Instr_valid & Instr_ready;
    assign Instr        = Instr_valid ? instr_mem[rd_q] : '0;
    assign Instr_PC     = Instr_valid ? pc_mem[rd_q]    : '0;

    assign redirect_sum = Redirect_base + XLEN'(4) + Redirect_immed;
    assign redirect_tgt = redirect_sum & ~(XLEN'(3));

    assign Dbg_state    = state_q;
`ifdef IF_PERF_CNT_EN
    assign Perf_fetched = fetched_q;
    assign Perf_flushes = flushes_q;
`endif

    always_comb begin
        pc_d    = pc_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (Redirect) begin
            pc_d    = redirect_tgt;
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (Imem_en) pc_d = pc_q + XLEN'(4);
            if (push)    wr_d = wr_q + PW'(1);
            if (pop)     rd_d = rd_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
`ifdef IF_PERF_CNT_EN
            fetched_q  <= '0;
            flushes_q  <= '0;
`endif
        end else begin
            pc_q       <= pc_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            inflight_q <= Imem_en;
            if (Imem_en) tag_q <= pc_q;
            if (Redirect)        state_q <= ST_KILL;
            else if (issue_cond) state_q <= ST_FETCH;
            else                 state_q <= ST_HOLD;
`ifdef IF_PERF_CNT_EN
            if (pop)      fetched_q <= fetched_q + 32'd1;
            if (Redirect) flushes_q <= flushes_q + 32'd1;
`endif
        end
    end

    // Queue storage carries no reset; occupancy is defined solely by count_q.
    always_ff @(posedge Clk) begin
        if (push && Reset) begin
            instr_mem[wr_q] <= Imem_rdata;
            pc_mem[wr_q]    <= tag_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage: ROM model, expected-stream scoreboard and directed checks.
// Checks the perf counters as well when IF_PERF_CNT_EN is defined.
module tb_fetch_queue_stage;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Fetch_en = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] Redirect_base = '0;
    logic [31:0] Redirect_immed = '0;
    logic        Imem_en;
    logic [9:0]  Imem_addr;
    logic [31:0] Imem_rdata = '0;
    logic [31:0] Instr;
    logic [31:0] Instr_PC;
    logic        Instr_valid;
    logic        Instr_ready = 1'b0;
    logic [1:0]  Dbg_state;
`ifdef IF_PERF_CNT_EN
    logic [31:0] Perf_fetched;
    logic [31:0] Perf_flushes;
`endif

    int vectors = 0;
    int miscompares = 0;
    int pops = 0;
    int flushes = 0;
    logic [63:0] exp_q[$];

    fetch_queue_stage dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Fetch_en       (Fetch_en),
        .Redirect       (Redirect),
        .Redirect_base  (Redirect_base),
        .Redirect_immed (Redirect_immed),
        .Imem_en        (Imem_en),
        .Imem_addr      (Imem_addr),
        .Imem_rdata     (Imem_rdata),
        .Instr          (Instr),
        .Instr_PC       (Instr_PC),
        .Instr_valid    (Instr_valid),
        .Instr_ready    (Instr_ready),
`ifdef IF_PERF_CNT_EN
        .Perf_fetched   (Perf_fetched),
        .Perf_flushes   (Perf_flushes),
`endif
        .Dbg_state      (Dbg_state)
    );

    // ---- clock ----
    always #5 Clk = ~Clk;

    // ---- ROM model: word i holds i*0x11, one-cycle read latency ----
    function automatic logic [31:0] rom_word(input logic [9:0] a);
        return {22'd0, a} * 32'h11;
    endfunction

    always @(posedge Clk) begin
        if (Imem_en) Imem_rdata <= rom_word(Imem_addr);
    end

    // ---- checking ----
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected program order from a new fetch origin.
    task automatic exp_fill(input logic [31:0] start);
        logic [31:0] pc;
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            pc = start + 32'(i * 4);
            exp_q.push_back({pc, rom_word(pc[11:2])});
        end
    endtask

    // ---- scoreboard: compare every accepted head word ----
    always @(negedge Clk) begin
        logic [63:0] e;
        if (Reset && Instr_valid && Instr_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                check("pop_unexpected", Instr_PC, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("pop_pc", Instr_PC, e[63:32]);
                check("pop_instr", Instr, e[31:0]);
            end
        end
    end

    // ---- driver tasks ----
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    // Leaves the bench in cycle 0 after reset release (posedge + 1).
    task automatic do_reset(input logic ready);
        Reset       = 1'b0;
        Redirect    = 1'b0;
        Fetch_en    = 1'b1;
        Instr_ready = ready;
        repeat (2) cyc();
        exp_fill(32'h0);
        pops    = 0;
        flushes = 0;
        Reset   = 1'b1;
    endtask

    // Pulses Redirect for one cycle; returns in the following cycle.
    task automatic redirect(input logic [31:0] b, input logic [31:0] imm, input logic [31:0] tgt);
        Redirect       = 1'b1;
        Redirect_base  = b;
        Redirect_immed = imm;
        flushes++;
        exp_fill(tgt);
        #1;
        check("rd_valid_low", 32'(Instr_valid), 32'd0);
        check("rd_no_issue", 32'(Imem_en), 32'd0);
        cyc();
        Redirect = 1'b0;
        #1;
        check("rd_state_kill", 32'(Dbg_state), 32'd2);
        check("rd_addr", 32'(Imem_addr), 32'(tgt[11:2]));
        check("rd_valid_empty", 32'(Instr_valid), 32'd0);
    endtask

    initial begin
        // Streaming from reset, decode always ready.
        do_reset(1'b1);
        #1;
        check("c0_valid", 32'(Instr_valid), 32'd0);
        check("c0_en", 32'(Imem_en), 32'd1);
        check("c0_addr", 32'(Imem_addr), 32'd0);
        cyc();
        check("c1_valid", 32'(Instr_valid), 32'd0);
        cyc();
        check("c2_valid", 32'(Instr_valid), 32'd1);
        check("c2_instr", Instr, 32'h0);
        check("c2_pc", Instr_PC, 32'h0);
        repeat (6) cyc();
        check("stream_pops", 32'(pops), 32'd6);

        // Decode stalled: queue fills to DEPTH, issue stops, nothing lost on release.
        do_reset(1'b0);
        repeat (10) cyc();
        check("full_en", 32'(Imem_en), 32'd0);
        check("full_valid", 32'(Instr_valid), 32'd1);
        check("full_head_pc", Instr_PC, 32'h0);
        check("full_state_hold", 32'(Dbg_state), 32'd1);
        Instr_ready = 1'b1;
        repeat (8) cyc();
        check("drain_pops_ge4", 32'(pops >= 4), 32'd1);

        // Redirect with three queued entries and one in flight.
        do_reset(1'b0);
        repeat (4) cyc();
        redirect(32'h10, 32'h20, 32'h34);
        check("rc_en", 32'(Imem_en), 32'd1);
        Instr_ready = 1'b1;
        repeat (6) cyc();
        check("rc_pops", 32'(pops), 32'd4);

        // Redirect in a cycle with a pending pop and a returning word.
        do_reset(1'b1);
        repeat (6) cyc();
        check("rp_valid_before", 32'(Instr_valid), 32'd1);
        redirect(32'h100, 32'h40, 32'h144);
        check("rp_pops", 32'(pops), 32'd4);
`ifdef IF_PERF_CNT_EN
        check("rp_perf_fetched", Perf_fetched, 32'(pops));
        check("rp_perf_flushes", Perf_flushes, 32'(flushes));
`endif
        repeat (5) cyc();

        // Target arithmetic: wrap and word alignment.
        redirect(32'hFFFF_FFFC, 32'h0, 32'h0);
        check("wrap_en", 32'(Imem_en), 32'd1);
        repeat (4) cyc();
        redirect(32'h20, 32'h3, 32'h24);
        repeat (4) cyc();

        // Redirect while fetch disabled still moves PC and flushes.
        Fetch_en = 1'b0;
        redirect(32'h200, 32'h0, 32'h204);
        check("fd_en", 32'(Imem_en), 32'd0);
        cyc();
        check("fd_valid", 32'(Instr_valid), 32'd0);
        check("fd_addr", 32'(Imem_addr), 32'h81);
        Fetch_en = 1'b1;
        #1;
        check("fd_en_resume", 32'(Imem_en), 32'd1);
        repeat (5) cyc();
`ifdef IF_PERF_CNT_EN
        check("pf_fetched", Perf_fetched, 32'(pops));
        check("pf_flushes", Perf_flushes, 32'(flushes));
`endif

        // Reset mid-stream discards everything.
        check("mr_valid_before", 32'(Instr_valid), 32'd1);
        Reset = 1'b0;
        #1;
        check("mr_en_during", 32'(Imem_en), 32'd0);
        cyc();
        check("mr_valid", 32'(Instr_valid), 32'd0);
        check("mr_addr", 32'(Imem_addr), 32'd0);
        check("mr_instr", Instr, 32'd0);
        check("mr_pc", Instr_PC, 32'd0);
        check("mr_state", 32'(Dbg_state), 32'd0);
`ifdef IF_PERF_CNT_EN
        check("mr_perf_fetched", Perf_fetched, 32'd0);
        check("mr_perf_flushes", Perf_flushes, 32'd0);
`endif
        Reset = 1'b1;
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
